// File: rtl/nios_system_sysid_pkg.sv
// rtl/nios_system_sysid_pkg.sv - shared state type and constants for the sysid boot checker
package nios_system_sysid_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_ID,
    S_WAIT_ID,
    S_REQ_TS,
    S_WAIT_TS,
    S_FINISH
  } sysid_chk_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Regenerated together with the sysid slave so the checker tracks the current build.
  localparam logic [31:0] SYSID_EXPECTED_TS = 32'h5805_6E47;

endpackage

// File: rtl/nios_system_sysid_timeout.sv
// rtl/nios_system_sysid_timeout.sv - loadable saturating down-counter bounding the read response wait
module nios_system_sysid_timeout
  import nios_system_sysid_pkg::*;
#(
  parameter int unsigned CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(CYCLES + 1);

  logic [W-1:0] count;

  // Loaded on acceptance so that the CYCLES-th waiting cycle is the one that sees zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= W'(CYCLES - 1);
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/nios_system_sysid_checker.sv
// rtl/nios_system_sysid_checker.sv - boot-time Avalon-MM reader that verifies system ID and build timestamp
module nios_system_sysid_checker
  import nios_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = SYSID_EXPECTED_TS,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MAX_RETRIES    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  sysid_chk_state_t state;
  logic [2:0]       retries;
  logic             tmo_load;
  logic             tmo_en;
  logic             tmo_expired;

  assign tmo_load = ((state == S_REQ_ID) || (state == S_REQ_TS)) && !avm_waitrequest;
  assign tmo_en   = (state == S_WAIT_ID) || (state == S_WAIT_TS);

  nios_system_sysid_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .load    (tmo_load),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      avm_address <= SYSID_ADDR_ID;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
      retries     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
            retries     <= '0;
            busy        <= 1'b1;
            avm_read    <= 1'b1;
            avm_address <= SYSID_ADDR_ID;
            state       <= S_REQ_ID;
          end
        end
        S_REQ_ID: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= S_WAIT_ID;
          end
        end
        S_REQ_TS: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= S_WAIT_TS;
          end
        end
        S_WAIT_ID, S_WAIT_TS: begin
          // A response in the expiry cycle still counts, so data is tested before the timeout.
          if (avm_readdatavalid) begin
            if (state == S_WAIT_ID) begin
              id_value    <= avm_readdata;
              id_ok       <= (avm_readdata == EXPECTED_ID);
              avm_read    <= 1'b1;
              avm_address <= SYSID_ADDR_TS;
              state       <= S_REQ_TS;
            end else begin
              ts_value <= avm_readdata;
              ts_ok    <= (avm_readdata == EXPECTED_TS);
              state    <= S_FINISH;
            end
          end else if (tmo_expired) begin
            if (retries < 3'(MAX_RETRIES)) begin
              retries     <= retries + 1'b1;
              id_ok       <= 1'b0;
              ts_ok       <= 1'b0;
              avm_read    <= 1'b1;
              avm_address <= SYSID_ADDR_ID;
              state       <= S_REQ_ID;
            end else begin
              timeout_err <= 1'b1;
              state       <= S_FINISH;
            end
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// tb/tb_nios_system_sysid_checker.sv - scoreboard bench for the sysid boot checker
module tb_nios_system_sysid_checker;

  localparam logic [31:0] EXP_ID  = 32'h0000_0000;
  localparam logic [31:0] EXP_TS  = 32'h5805_6E47;
  localparam int          TMO     = 16;
  localparam int          RETRIES = 2;

  logic        clock;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout_err;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  nios_system_sysid_checker dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .id_ok             (id_ok),
    .ts_ok             (ts_ok),
    .timeout_err       (timeout_err),
    .id_value          (id_value),
    .ts_value          (ts_value)
  );

  typedef struct {
    int          cyc;
    logic        id_ok;
    logic        ts_ok;
    logic        tmo;
    logic [31:0] idv;
    logic [31:0] tsv;
  } exp_t;

  exp_t        sb[$];
  int          acc_cyc[$];
  logic        acc_addr[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          cfg_wait[2];
  int          cfg_lat[2];
  logic [31:0] cfg_data[2];
  bit          cfg_resp;
  bit          force_rdv;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Sysid slave: per-address wait states and response latency, records every acceptance.
  initial begin : slave
    int          wait_left;
    bit          req_active;
    bit          stalled;
    logic        stall_addr;
    bit          pend;
    int          due;
    logic [31:0] pdata;
    req_active = 0; stalled = 0; pend = 0; due = 0; wait_left = 0; stall_addr = 0; pdata = 0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        req_active = 0;
        stalled = 0;
      end
      if (stalled) chk("stall_hold", {avm_read, avm_address}, {1'b1, stall_addr});
      stalled = 0;
      avm_waitrequest = 1'b0;
      if (avm_read && !reset) begin
        if (!req_active) begin
          req_active = 1;
          wait_left = cfg_wait[avm_address];
        end
        if (wait_left > 0) begin
          wait_left--;
          avm_waitrequest = 1'b1;
          stalled = 1;
          stall_addr = avm_address;
        end else begin
          req_active = 0;
          acc_cyc.push_back(cyc);
          acc_addr.push_back(avm_address);
          if (cfg_resp) begin
            pend = 1;
            due = cyc + cfg_lat[avm_address];
            pdata = cfg_data[avm_address];
          end
        end
      end
      avm_readdatavalid = 1'b0;
      avm_readdata = $urandom;
      if (force_rdv) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = EXP_TS;
      end else if (pend && cyc == due) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = pdata;
        pend = 0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", done, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("id_ok", id_ok, e.id_ok);
          chk("ts_ok", ts_ok, e.ts_ok);
          chk("timeout_err", timeout_err, e.tmo);
          chk("id_value", id_value, e.idv);
          chk("ts_value", ts_value, e.tsv);
          chk("busy_at_done", busy, 1'b0);
        end
      end
    end
  end

  task automatic set_cfg(input int wi, input int wt, input int li, input int lt, input bit resp,
                         input logic [31:0] di, input logic [31:0] dt);
    cfg_wait[0] = wi; cfg_wait[1] = wt;
    cfg_lat[0]  = li; cfg_lat[1]  = lt;
    cfg_resp    = resp;
    cfg_data[0] = di; cfg_data[1] = dt;
    acc_cyc.delete();
    acc_addr.delete();
  endtask

  // Reference outcome from the protocol rules: each read costs (waits+1) request cycles plus
  // its latency, finish adds one cycle; no response means every attempt burns TMO wait cycles.
  task automatic push_expect();
    exp_t e;
    if (cfg_resp) e.cyc = cyc + 4 + cfg_wait[0] + cfg_lat[0] + cfg_wait[1] + cfg_lat[1];
    else          e.cyc = cyc + 2 + (RETRIES + 1) * (cfg_wait[0] + 1 + TMO);
    e.id_ok = cfg_resp && (cfg_data[0] == EXP_ID);
    e.ts_ok = cfg_resp && (cfg_data[1] == EXP_TS);
    e.tmo   = !cfg_resp;
    e.idv   = cfg_resp ? cfg_data[0] : 32'h0;
    e.tsv   = cfg_resp ? cfg_data[1] : 32'h0;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && sb.size() != 0; i++) step();
    chk({tag, "_drained"}, sb.size(), 0);
    sb.delete();
    step();
  endtask

  task automatic run_seq(input int wi, input int wt, input int li, input int lt, input bit resp,
                         input logic [31:0] di, input logic [31:0] dt, input string tag);
    set_cfg(wi, wt, li, lt, resp, di, dt);
    push_expect();
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_cleared"}, {busy, id_ok, ts_ok, timeout_err, id_value, ts_value}, {1'b1, 67'b0});
    drain(tag);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin : stim
    int sc;
    int ones;
    reset = 1'b1; start = 1'b0; force_rdv = 1'b0;
    set_cfg(0, 0, 1, 1, 1, EXP_ID, EXP_TS);
    repeat (3) step();
    chk("reset_outputs", {avm_read, avm_address, busy, done, id_ok, ts_ok, timeout_err, id_value, ts_value}, 0);
    reset = 1'b0;
    step();

    run_seq(0, 0, 1, 1, 1, EXP_ID, EXP_TS, "t1");
    chk("t1_accepts", acc_addr.size(), 2);
    if (acc_addr.size() == 2) begin
      chk("t1_addr_first", acc_addr[0], 1'b0);
      chk("t1_addr_second", acc_addr[1], 1'b1);
    end

    run_seq(0, 0, 1, 1, 1, EXP_ID, EXP_TS + 32'd1, "t2");

    run_seq(5, 0, 1, 1, 1, EXP_ID, EXP_TS, "t3");
    chk("t3_accepts", acc_addr.size(), 2);

    run_seq(0, 0, 1, 1, 0, EXP_ID, EXP_TS, "t4");
    chk("t4_attempts", acc_addr.size(), RETRIES + 1);
    ones = 0;
    foreach (acc_addr[i]) ones += int'(acc_addr[i]);
    chk("t4_only_id_reads", ones, 0);
    for (int i = 1; i < acc_cyc.size(); i++) chk("t4_gap", acc_cyc[i] - acc_cyc[i-1] - 1, TMO);

    run_seq(0, 0, TMO, TMO, 1, EXP_ID, EXP_TS, "lat_max");

    // Reset while a stalled ID request is outstanding.
    set_cfg(8, 0, 1, 1, 1, EXP_ID, EXP_TS);
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("reset_drops_read", {avm_read, busy}, 2'b00);
    step();

    // Reset during WAIT_TS, then the late response and stray strobes must be ignored.
    set_cfg(0, 0, 1, 10, 1, EXP_ID, EXP_TS);
    sc = cyc;
    start = 1'b1; step(); start = 1'b0;
    while (cyc < sc + 6) step();
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      force_rdv = (i == 1 || i == 2);
      chk("t5_quiet", {avm_read, busy, done, id_ok, ts_ok, timeout_err, id_value, ts_value}, 0);
      step();
    end
    force_rdv = 1'b0;
    run_seq(0, 0, 1, 1, 1, EXP_ID, EXP_TS, "t5_after");

    // Start while busy and in the finish cycle must not restart.
    set_cfg(0, 0, 1, 1, 1, EXP_ID, EXP_TS);
    push_expect();
    start = 1'b1; step(); start = 1'b0;
    step();
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    start = 1'b1; step(); start = 1'b0;
    step();
    chk("t6_idle", {busy, avm_read}, 2'b00);
    drain("t6");
    run_seq(0, 0, 1, 1, 1, 32'h1234_5678, EXP_TS, "t6_fresh");
    run_seq(0, 0, 1, 1, 0, EXP_ID, EXP_TS, "t6_tmo");
    run_seq(0, 0, 1, 1, 1, EXP_ID, EXP_TS, "t6_clear_tmo");

    for (int n = 0; n < 8; n++) begin
      logic [31:0] di;
      logic [31:0] dt;
      di = ($urandom_range(0, 1) == 1) ? EXP_ID : 32'($urandom);
      dt = ($urandom_range(0, 1) == 1) ? EXP_TS : 32'($urandom);
      run_seq($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, TMO),
              $urandom_range(1, TMO), 1, di, dt, "rand");
    end

    repeat (20) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
